// File: rtl/coherence_arbiter.sv
// Two-core coherence arbiter: serialises dcache/icache traffic onto one shared
// RAM port and forwards snoops, including dirty-line cache-to-cache writeback.
module coherence_arbiter (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       dREN,
  input  logic [1:0]       dWEN,
  input  logic [1:0][31:0] daddr,
  input  logic [1:0][31:0] dstore,
  input  logic [1:0]       ccwrite,
  input  logic [1:0]       cctrans,
  input  logic [1:0]       iREN,
  input  logic [1:0][31:0] iaddr,
  output logic [1:0]       dwait,
  output logic [1:0]       iwait,
  output logic [1:0][31:0] dload,
  output logic [1:0][31:0] iload,
  output logic [1:0]       ccwait,
  output logic [1:0]       ccinv,
  output logic [1:0][31:0] ccsnoopaddr,
  output logic             ramREN,
  output logic             ramWEN,
  output logic [31:0]      ramaddr,
  output logic [31:0]      ramstore,
  input  logic [31:0]      ramload,
  input  logic [1:0]       ramstate
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DWRITE  = 3'd1,
    SNOOP   = 3'd2,
    C2C     = 3'd3,
    RAMREAD = 3'd4,
    IFETCH  = 3'd5
  } state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;

  state_t state_q, state_d;
  logic   dgnt_q, dgnt_d;
  logic   ignt_q, ignt_d;
  logic   dlast_q, dlast_d;
  logic   ilast_q, ilast_d;

  logic [1:0] dreq;
  logic       dpick, ipick, opp, ram_done;

  // Round-robin on a tie: the core that was not served last wins.
  function automatic logic pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

  assign dreq     = dREN | dWEN;
  assign dpick    = pick(dreq, dlast_q);
  assign ipick    = pick(iREN, ilast_q);
  assign opp      = ~dgnt_q;
  assign ram_done = (ramstate == RAM_ACCESS);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      dgnt_q  <= 1'b0;
      ignt_q  <= 1'b0;
      dlast_q <= 1'b1;
      ilast_q <= 1'b1;
    end else begin
      state_q <= state_d;
      dgnt_q  <= dgnt_d;
      ignt_q  <= ignt_d;
      dlast_q <= dlast_d;
      ilast_q <= ilast_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    dgnt_d      = dgnt_q;
    ignt_d      = ignt_q;
    dlast_d     = dlast_q;
    ilast_d     = ilast_q;
    dwait       = 2'b11;
    iwait       = 2'b11;
    dload       = '0;
    iload       = '0;
    ccwait      = 2'b00;
    ccinv       = 2'b00;
    ccsnoopaddr = '0;
    ramREN      = 1'b0;
    ramWEN      = 1'b0;
    ramaddr     = '0;
    ramstore    = '0;

    case (state_q)
      IDLE: begin
        if (|dreq) begin
          dgnt_d  = dpick;
          state_d = dWEN[dpick] ? DWRITE : SNOOP;
        end else if (|iREN) begin
          ignt_d  = ipick;
          state_d = IFETCH;
        end
      end

      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr[dgnt_q];
        ramstore = dstore[dgnt_q];
        if (ram_done) dwait[dgnt_q] = 1'b0;
        if (!dWEN[dgnt_q]) begin
          state_d = IDLE;
          dlast_d = dgnt_q;
        end
      end

      SNOOP: begin
        ccwait[opp]      = 1'b1;
        ccsnoopaddr[opp] = daddr[dgnt_q];
        ccinv[opp]       = ccwrite[dgnt_q];
        // An abandoned request returns to IDLE without touching RAM or dlast.
        if (!dREN[dgnt_q] && !dWEN[dgnt_q]) state_d = IDLE;
        else if (cctrans[opp])              state_d = ccwrite[opp] ? C2C : RAMREAD;
      end

      C2C: begin
        ccwait[opp]      = 1'b1;
        ccsnoopaddr[opp] = daddr[dgnt_q];
        ramWEN           = 1'b1;
        ramaddr          = daddr[opp];
        ramstore         = dstore[opp];
        if (ram_done) dwait[opp] = 1'b0;
        if (!dWEN[opp]) state_d = RAMREAD;
      end

      RAMREAD: begin
        ramREN        = 1'b1;
        ramaddr       = daddr[dgnt_q];
        dload[dgnt_q] = ramload;
        if (ram_done) dwait[dgnt_q] = 1'b0;
        if (!dREN[dgnt_q]) begin
          state_d = IDLE;
          dlast_d = dgnt_q;
        end
      end

      IFETCH: begin
        ramREN        = 1'b1;
        ramaddr       = iaddr[ignt_q];
        iload[ignt_q] = ramload;
        if (ram_done) begin
          iwait[ignt_q] = 1'b0;
          state_d       = IDLE;
          ilast_d       = ignt_q;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_coherence_arbiter.sv
// Directed bench for coherence_arbiter: snoop reads, round-robin ties,
// dirty cache-to-cache writeback, RAM stalls, icache fetch and mid-flight reset.
module tb_coherence_arbiter;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2;

  logic             CLK = 1'b0;
  logic             RST;
  logic [1:0]       dREN, dWEN, ccwrite, cctrans, iREN;
  logic [1:0][31:0] daddr, dstore, iaddr;
  logic [1:0]       dwait, iwait, ccwait, ccinv;
  logic [1:0][31:0] dload, iload, ccsnoopaddr;
  logic             ramREN, ramWEN;
  logic [31:0]      ramaddr, ramstore, ramload;
  logic [1:0]       ramstate;

  int n_checks = 0;
  int n_fail   = 0;

  coherence_arbiter dut (
    .CLK(CLK), .RST(RST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .ccwrite(ccwrite), .cctrans(cctrans),
    .iREN(iREN), .iaddr(iaddr),
    .dwait(dwait), .iwait(iwait), .dload(dload), .iload(iload),
    .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    dREN = '0; dWEN = '0; ccwrite = '0; cctrans = '0; iREN = '0;
    daddr = '0; dstore = '0; iaddr = '0;
  endtask

  initial begin
    clear_inputs();
    ramload  = 32'hDEADBEEF;
    ramstate = FREE;
    RST      = 1'b1;
    #2;
    chk("rst_dwait",  {30'd0, dwait},  32'h3);
    chk("rst_iwait",  {30'd0, iwait},  32'h3);
    chk("rst_ramREN", {31'd0, ramREN}, 32'h0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'h0);
    chk("rst_ccwait", {30'd0, ccwait}, 32'h0);
    tick();
    RST = 1'b0;

    // Core0 read, clean snoop response from core1.
    tick();
    dREN[0] = 1'b1; daddr[0] = 32'h100;
    cctrans[1] = 1'b1; ramstate = ACCESS;
    #1;
    chk("rd_idle_dwait",  {30'd0, dwait},  32'h3);
    chk("rd_idle_ramREN", {31'd0, ramREN}, 32'h0);
    tick();
    chk("rd_snp_ccwait",  {30'd0, ccwait}, 32'h2);
    chk("rd_snp_addr",    ccsnoopaddr[1],  32'h100);
    chk("rd_snp_ccinv",   {30'd0, ccinv},  32'h0);
    chk("rd_snp_ramREN",  {31'd0, ramREN}, 32'h0);
    chk("rd_snp_dwait",   {30'd0, dwait},  32'h3);
    tick();
    chk("rd_ram_ramREN",  {31'd0, ramREN}, 32'h1);
    chk("rd_ram_addr",    ramaddr,         32'h100);
    chk("rd_ram_dwait",   {30'd0, dwait},  32'h2);
    chk("rd_ram_dload",   dload[0],        32'hDEADBEEF);
    dREN[0] = 1'b0;
    tick();
    chk("rd_done_ramREN", {31'd0, ramREN}, 32'h0);
    chk("rd_done_dwait",  {30'd0, dwait},  32'h3);

    // Fresh reset so the next tie starts from dlast=1.
    #2; RST = 1'b1; #1;
    chk("rst2_dwait", {30'd0, dwait}, 32'h3);
    tick();
    RST = 1'b0;

    // Simultaneous reads: core0, then core1, then core0 again.
    tick();
    dREN = 2'b11; daddr[0] = 32'h10; daddr[1] = 32'h20; cctrans = 2'b11;
    tick();
    chk("tie1_ccwait", {30'd0, ccwait}, 32'h2);
    chk("tie1_snaddr", ccsnoopaddr[1],  32'h10);
    tick();
    chk("tie1_addr",   ramaddr,         32'h10);
    chk("tie1_dwait",  {30'd0, dwait},  32'h2);
    dREN[0] = 1'b0;
    tick();
    chk("tie1_idle_dwait", {30'd0, dwait}, 32'h3);
    tick();
    chk("tie2_ccwait", {30'd0, ccwait}, 32'h1);
    chk("tie2_snaddr", ccsnoopaddr[0],  32'h20);
    tick();
    chk("tie2_addr",   ramaddr,         32'h20);
    chk("tie2_dwait",  {30'd0, dwait},  32'h1);
    dREN[1] = 1'b0;
    tick();
    dREN = 2'b11;
    tick();
    chk("tie3_ccwait", {30'd0, ccwait}, 32'h2);
    // Requester abandons during snoop: back to IDLE with no RAM access.
    dREN = 2'b00;
    tick();
    chk("abort_ramREN", {31'd0, ramREN}, 32'h0);
    chk("abort_ramWEN", {31'd0, ramWEN}, 32'h0);
    chk("abort_ccwait", {30'd0, ccwait}, 32'h0);
    dREN = 2'b11;
    tick();
    chk("tie4_ccwait", {30'd0, ccwait}, 32'h2);
    dREN = 2'b00; cctrans = 2'b00;
    tick();

    // Core1 read-for-write; core0 holds the line dirty and writes back two words.
    dREN[1] = 1'b1; ccwrite[1] = 1'b1; daddr[1] = 32'h300;
    ramload = 32'h5A5A1234;
    tick();
    chk("c2c_snp_ccinv",  {30'd0, ccinv},  32'h1);
    chk("c2c_snp_ccwait", {30'd0, ccwait}, 32'h1);
    chk("c2c_snp_addr",   ccsnoopaddr[0],  32'h300);
    chk("c2c_snp_ramWEN", {31'd0, ramWEN}, 32'h0);
    cctrans[0] = 1'b1; ccwrite[0] = 1'b1; dWEN[0] = 1'b1;
    daddr[0] = 32'h200; dstore[0] = 32'h11112222;
    tick();
    chk("c2c_w0_ramWEN", {31'd0, ramWEN}, 32'h1);
    chk("c2c_w0_addr",   ramaddr,         32'h200);
    chk("c2c_w0_store",  ramstore,        32'h11112222);
    chk("c2c_w0_dwait",  {30'd0, dwait},  32'h2);
    chk("c2c_w0_ccwait", {30'd0, ccwait}, 32'h1);
    daddr[0] = 32'h204; dstore[0] = 32'h33334444;
    tick();
    chk("c2c_w1_ramWEN", {31'd0, ramWEN}, 32'h1);
    chk("c2c_w1_addr",   ramaddr,         32'h204);
    chk("c2c_w1_store",  ramstore,        32'h33334444);
    dWEN[0] = 1'b0; cctrans[0] = 1'b0; ccwrite[0] = 1'b0;
    tick();
    chk("c2c_rd_ramREN", {31'd0, ramREN}, 32'h1);
    chk("c2c_rd_addr",   ramaddr,         32'h300);
    chk("c2c_rd_dwait",  {30'd0, dwait},  32'h1);
    chk("c2c_rd_dload",  dload[1],        32'h5A5A1234);
    dREN[1] = 1'b0; ccwrite[1] = 1'b0;
    tick();

    // RAM busy for five cycles during a read.
    dREN[0] = 1'b1; daddr[0] = 32'h400; cctrans[1] = 1'b1; ramstate = BUSY;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("busy_dwait", {30'd0, dwait}, 32'h3);
      tick();
    end
    ramstate = ACCESS;
    #1;
    chk("busy_done_dwait", {30'd0, dwait}, 32'h2);
    dREN[0] = 1'b0; cctrans = 2'b00;
    tick();

    // Core0 write and core1 fetch together: write first.
    dWEN[0] = 1'b1; daddr[0] = 32'h500; dstore[0] = 32'hCAFEF00D;
    iREN[1] = 1'b1; iaddr[1] = 32'h600; ramload = 32'h0BADC0DE;
    tick();
    chk("wr_ramWEN", {31'd0, ramWEN}, 32'h1);
    chk("wr_addr",   ramaddr,         32'h500);
    chk("wr_store",  ramstore,        32'hCAFEF00D);
    chk("wr_dwait",  {30'd0, dwait},  32'h2);
    chk("wr_iwait",  {30'd0, iwait},  32'h3);
    dWEN[0] = 1'b0;
    tick();
    chk("if_idle_iwait", {30'd0, iwait}, 32'h3);
    tick();
    chk("if_ramREN", {31'd0, ramREN}, 32'h1);
    chk("if_addr",   ramaddr,         32'h600);
    chk("if_iwait",  {30'd0, iwait},  32'h1);
    chk("if_iload",  iload[1],        32'h0BADC0DE);
    iREN[1] = 1'b0;
    tick();
    chk("if_done_ramREN", {31'd0, ramREN}, 32'h0);

    // Reset asserted in the middle of a cache-to-cache writeback.
    dREN[0] = 1'b1; ccwrite[0] = 1'b1; daddr[0] = 32'h700;
    tick();
    cctrans[1] = 1'b1; ccwrite[1] = 1'b1; dWEN[1] = 1'b1; daddr[1] = 32'h780;
    tick();
    chk("rc_c2c_ramWEN", {31'd0, ramWEN}, 32'h1);
    chk("rc_c2c_ccwait", {30'd0, ccwait}, 32'h2);
    #2; RST = 1'b1; #1;
    chk("rc_ramWEN", {31'd0, ramWEN}, 32'h0);
    chk("rc_ccwait", {30'd0, ccwait}, 32'h0);
    chk("rc_dwait",  {30'd0, dwait},  32'h3);
    chk("rc_ramREN", {31'd0, ramREN}, 32'h0);
    clear_inputs();
    tick();
    RST = 1'b0;

    // Post-reset icache tie goes to core0.
    iREN = 2'b11; iaddr[0] = 32'h800; iaddr[1] = 32'h900;
    tick();
    chk("itie_addr",  ramaddr,        32'h800);
    chk("itie_iwait", {30'd0, iwait}, 32'h2);
    iREN = 2'b00;
    tick();
    chk("itie_done_ramREN", {31'd0, ramREN}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
